// File: rtl/fsgn_result_buf_pkg.sv
// Shared FPU definitions used by the sign-injection result buffer:
// RISC-V fmt encodings, format widths and buffer occupancy states.
package fsgn_result_buf_pkg;

    localparam logic [1:0] S_FMT = 2'b00;
    localparam logic [1:0] D_FMT = 2'b01;
    localparam logic [1:0] H_FMT = 2'b10;
    localparam logic [1:0] Q_FMT = 2'b11;

    localparam int S_LEN = 32;
    localparam int D_LEN = 64;
    localparam int H_LEN = 16;
    localparam int Q_LEN = 128;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    function automatic int fmt_len(input logic [1:0] fmt);
        int len;
        case (fmt)
            S_FMT:   len = S_LEN;
            D_FMT:   len = D_LEN;
            H_FMT:   len = H_LEN;
            default: len = Q_LEN;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fsgn_result_buf_boxchk.sv
// Combinational NaN-box check: every bit above the format width must be one.
// A format wider than the register cannot be boxed and reports 0.
module fsgn_boxchk
    import fsgn_result_buf_pkg::*;
#(
    parameter int FLEN    = 64,
    parameter int FMTBITS = 2
) (
    input  logic [FLEN-1:0]    res,
    input  logic [FMTBITS-1:0] fmt,
    output logic               ok
);

    function automatic logic box_ok(input logic [FLEN-1:0] r, input int w);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            if (i >= w && !r[i]) all_ones = 1'b0;
        end
        if (w > FLEN) all_ones = 1'b0;
        return all_ones;
    endfunction

    always_comb begin
        ok = 1'b0;
        // Encodings outside the 2-bit fmt space are treated as unboxable.
        if (fmt == FMTBITS'(fmt[1:0])) begin
            ok = box_ok(res, fmt_len(fmt[1:0]));
        end
    end

endmodule

// File: rtl/fsgn_result_buf.sv
// Two-entry skid buffer between FPU sign injection and writeback.
// Registered in_ready and register-sourced outputs break the stall path.
module fsgn_result_buf
    import fsgn_result_buf_pkg::*;
#(
    parameter int FLEN    = 64,
    parameter int FMTBITS = 2,
    parameter int TAGW    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLEN-1:0]    in_res,
    input  logic [FMTBITS-1:0] in_fmt,
    input  logic [TAGW-1:0]    in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLEN-1:0]    out_res,
    output logic [FMTBITS-1:0] out_fmt,
    output logic [TAGW-1:0]    out_tag,
    output logic               out_boxok
);

    occ_e               state_q;
    occ_e               state_d;
    logic               wr_ptr;
    logic               rd_ptr;
    logic               push;
    logic               pop;
    logic               box_ok;

    logic [FLEN-1:0]    res_mem [2];
    logic [FMTBITS-1:0] fmt_mem [2];
    logic [TAGW-1:0]    tag_mem [2];
    logic               box_mem [2];

    fsgn_boxchk #(
        .FLEN    (FLEN),
        .FMTBITS (FMTBITS)
    ) u_boxchk (
        .res (in_res),
        .fmt (in_fmt),
        .ok  (box_ok)
    );

    assign out_valid = (state_q != EMPTY) && !flush;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    assign out_res   = res_mem[rd_ptr];
    assign out_fmt   = fmt_mem[rd_ptr];
    assign out_tag   = tag_mem[rd_ptr];
    assign out_boxok = box_mem[rd_ptr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            // Ready is derived from the next occupancy, so a pop from FULL
            // only reopens the input on the following cycle.
            in_ready <= (state_d != FULL);
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                res_mem[i] <= '0;
                fmt_mem[i] <= '0;
                tag_mem[i] <= '0;
                box_mem[i] <= 1'b0;
            end
        end else if (push) begin
            res_mem[wr_ptr] <= in_res;
            fmt_mem[wr_ptr] <= in_fmt;
            tag_mem[wr_ptr] <= in_tag;
            box_mem[wr_ptr] <= box_ok;
        end
    end

endmodule
